// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the two-way intersection controller.
package traffic_light_pkg;

  // Width of the per-phase cycle counter; durations up to 255 fit without wrap.
  localparam int CNT_W = 8;

  // Lamp encodings for one signal head: bit2 red, bit1 yellow, bit0 green.
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // Phases in their fixed cyclic order; codes 6 and 7 are never used.
  typedef enum logic [2:0] {
    S_AG  = 3'd0,
    S_AY  = 3'd1,
    S_RR1 = 3'd2,
    S_BG  = 3'd3,
    S_BY  = 3'd4,
    S_RR2 = 3'd5
  } tl_state_e;

  // True for the six encodings the sequencer is allowed to occupy.
  function automatic logic is_legal_state(input tl_state_e s);
    logic legal;
    legal = 1'b0;
    case (s)
      S_AG, S_AY, S_RR1, S_BG, S_BY, S_RR2: legal = 1'b1;
      default:                              legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: counts cycles spent in the current phase and flags the last one.
module phase_timer
  import traffic_light_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_duration,
  output logic             o_terminal
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_lastCount;

  // The final cycle of a phase is count == duration-1; a count beyond that
  // (only reachable after an upset) is also treated as final so it cannot wrap.
  assign w_lastCount = i_duration - 1'b1;
  assign o_terminal  = (r_count >= w_lastCount);

  // Count up each cycle, reloading to zero whenever the phase ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_control.sv
// Two-way intersection controller: Moore sequencer over green, yellow and
// all-red clearance phases, with per-phase durations fixed by parameters.
module traffic_light_control
  import traffic_light_pkg::*;
#(
  parameter int GREEN_TIME   = 30,
  parameter int YELLOW_TIME  = 5,
  parameter int ALL_RED_TIME = 2
)(
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] light_A,
  output logic [2:0] light_B
);

  // Durations outside 1..255 cannot be represented by the phase counter.
  if (GREEN_TIME < 1 || GREEN_TIME > 255 ||
      YELLOW_TIME < 1 || YELLOW_TIME > 255 ||
      ALL_RED_TIME < 1 || ALL_RED_TIME > 255) begin : g_badDuration
    $error("traffic_light_control: every phase duration must be in 1..255");
  end

  localparam logic [CNT_W-1:0] GREEN_LEN  = CNT_W'(GREEN_TIME);
  localparam logic [CNT_W-1:0] YELLOW_LEN = CNT_W'(YELLOW_TIME);
  localparam logic [CNT_W-1:0] ALLRED_LEN = CNT_W'(ALL_RED_TIME);

  tl_state_e        r_state;
  tl_state_e        w_nextState;
  logic [CNT_W-1:0] w_phaseLen;
  logic             w_terminal;
  logic             w_illegal;
  logic             w_clear;

  assign w_illegal = !is_legal_state(r_state);

  // A phase ends on its last cycle; an unused encoding also restarts the count.
  assign w_clear = w_terminal | w_illegal;

  phase_timer u_timer (
    .clk        (clk),
    .rst_n      (rst),
    .i_clear    (w_clear),
    .i_duration (w_phaseLen),
    .o_terminal (w_terminal)
  );

  // Select how long the current phase lasts.
  always_comb begin
    w_phaseLen = GREEN_LEN;
    case (r_state)
      S_AG, S_BG:   w_phaseLen = GREEN_LEN;
      S_AY, S_BY:   w_phaseLen = YELLOW_LEN;
      S_RR1, S_RR2: w_phaseLen = ALLRED_LEN;
      default:      w_phaseLen = GREEN_LEN;
    endcase
  end

  // Hold the phase until its last cycle, then step to the next in the ring.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_AG:    if (w_terminal) w_nextState = S_AY;
      S_AY:    if (w_terminal) w_nextState = S_RR1;
      S_RR1:   if (w_terminal) w_nextState = S_BG;
      S_BG:    if (w_terminal) w_nextState = S_BY;
      S_BY:    if (w_terminal) w_nextState = S_RR2;
      S_RR2:   if (w_terminal) w_nextState = S_AG;
      default: w_nextState = S_AG;
    endcase
  end

  // State register; reset forces A green immediately, without a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_AG;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Lamps depend on the state register alone; unknown codes show all red.
  always_comb begin
    light_A = RED;
    light_B = RED;
    case (r_state)
      S_AG:    begin light_A = GRN; light_B = RED; end
      S_AY:    begin light_A = YEL; light_B = RED; end
      S_RR1:   begin light_A = RED; light_B = RED; end
      S_BG:    begin light_A = RED; light_B = GRN; end
      S_BY:    begin light_A = RED; light_B = YEL; end
      S_RR2:   begin light_A = RED; light_B = RED; end
      default: begin light_A = RED; light_B = RED; end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_control.sv
// Directed bench for traffic_light_control: default timing, shortest phases,
// longest green, mid-phase reset, invariants and illegal-state recovery.
module tb_traffic_light_control;
   import traffic_light_pkg::*;

   logic       clk;
   logic       rst;
   logic [2:0] defA, defB;
   logic [2:0] fastA, fastB;
   logic [2:0] longA, longB;

   int checkCount;
   int passCount;
   int edgeIdx;
   bit monitorOn;
   logic [2:0] prevDefA, prevDefB, prevFastA, prevFastB, prevLongA, prevLongB;

   traffic_light_control dutDef (
      .clk     (clk),
      .rst     (rst),
      .light_A (defA),
      .light_B (defB)
   );

   traffic_light_control #(
      .GREEN_TIME   (1),
      .YELLOW_TIME  (1),
      .ALL_RED_TIME (1)
   ) dutFast (
      .clk     (clk),
      .rst     (rst),
      .light_A (fastA),
      .light_B (fastB)
   );

   traffic_light_control #(
      .GREEN_TIME   (255),
      .YELLOW_TIME  (5),
      .ALL_RED_TIME (2)
   ) dutLong (
      .clk     (clk),
      .rst     (rst),
      .light_A (longA),
      .light_B (longB)
   );

   // Free-running 10 ns clock standing in for the 1 Hz tick.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every comparison and report any that disagree.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Arithmetic schedule of {A,B} lamps after k edges from a fresh start.
   function automatic logic [5:0] expectedLights(input int k, input int g,
                                                 input int y, input int r);
      int period;
      int p;
      period = 2 * (g + y + r);
      p      = k % period;
      if (p < g)                  return {GRN, RED};
      else if (p < g + y)         return {YEL, RED};
      else if (p < g + y + r)     return {RED, RED};
      else if (p < 2*g + y + r)   return {RED, GRN};
      else if (p < 2*g + 2*y + r) return {RED, YEL};
      else                        return {RED, RED};
   endfunction

   // Safety check on one head pair: one-hot, one road at most non-red, no green->red.
   function automatic logic violates(input logic [2:0] a, input logic [2:0] b,
                                     input logic [2:0] pa, input logic [2:0] pb);
      logic bad;
      bad = 1'b0;
      if (!$onehot(a) || !$onehot(b)) bad = 1'b1;
      if (a != RED && b != RED)       bad = 1'b1;
      if (pa == GRN && a == RED)      bad = 1'b1;
      if (pb == GRN && b == RED)      bad = 1'b1;
      return bad;
   endfunction

   // Advance n edges, comparing lamps #1 after each edge against the schedule.
   task automatic applyStimulus(input int nEdges, input bit allDuts);
      for (int i = 0; i < nEdges; i++) begin
         @(posedge clk);
         #1;
         edgeIdx++;
         checkOutput($sformatf("def edge %0d", edgeIdx), {26'b0, defA, defB},
                     32'(expectedLights(edgeIdx, 30, 5, 2)));
         if (allDuts) begin
            checkOutput($sformatf("fast edge %0d", edgeIdx), {26'b0, fastA, fastB},
                        32'(expectedLights(edgeIdx, 1, 1, 1)));
            checkOutput($sformatf("long edge %0d", edgeIdx), {26'b0, longA, longB},
                        32'(expectedLights(edgeIdx, 255, 5, 2)));
         end
      end
   endtask

   // Invariant watch on the falling edge while the sequence runs undisturbed.
   always @(negedge clk) begin
      if (monitorOn) begin
         checkOutput("invariant def", {31'b0, violates(defA, defB, prevDefA, prevDefB)}, 32'd0);
         checkOutput("invariant fast", {31'b0, violates(fastA, fastB, prevFastA, prevFastB)}, 32'd0);
         checkOutput("invariant long", {31'b0, violates(longA, longB, prevLongA, prevLongB)}, 32'd0);
      end
      prevDefA  = defA;
      prevDefB  = defB;
      prevFastA = fastA;
      prevFastB = fastB;
      prevLongA = longA;
      prevLongB = longB;
   end

   // Directed sequence of scenarios.
   initial begin
      checkCount = 0;
      passCount  = 0;
      edgeIdx    = 0;
      monitorOn  = 1'b0;
      rst        = 1'b0;

      #3;
      checkOutput("reset def", {26'b0, defA, defB}, {26'b0, GRN, RED});
      checkOutput("reset fast", {26'b0, fastA, fastB}, {26'b0, GRN, RED});
      checkOutput("reset long", {26'b0, longA, longB}, {26'b0, GRN, RED});

      @(negedge clk);
      rst       = 1'b1;
      edgeIdx   = 0;
      monitorOn = 1'b1;
      applyStimulus(1000, 1'b1);
      monitorOn = 1'b0;

      @(posedge clk);
      #2;
      checkOutput("pre-reset def B green", {26'b0, defA, defB}, {26'b0, RED, GRN});
      rst = 1'b0;
      #1;
      checkOutput("async reset def", {26'b0, defA, defB}, {26'b0, GRN, RED});
      checkOutput("async reset fast", {26'b0, fastA, fastB}, {26'b0, GRN, RED});
      @(negedge clk);
      @(negedge clk);
      checkOutput("held reset def", {26'b0, defA, defB}, {26'b0, GRN, RED});
      rst     = 1'b1;
      edgeIdx = 0;
      applyStimulus(40, 1'b1);

      @(negedge clk);
      force dutDef.r_state = tl_state_e'(3'd6);
      #1;
      release dutDef.r_state;
      @(posedge clk);
      #1;
      checkOutput("illegal recover def", {26'b0, defA, defB}, {26'b0, GRN, RED});
      edgeIdx = 0;
      applyStimulus(31, 1'b0);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/traffic_light_control.md
# traffic_light_control

Two-way intersection controller driving the signal heads of road A and road B from a single slow clock, nominally 1 Hz, so one cycle is one second. A Moore FSM sequences green, yellow and all-red clearance phases with per-phase durations set by parameters. It sits between the system clock/reset and the lamp drivers and has no other inputs.

## Interface
- `GREEN_TIME`, default 30: cycles a road holds green; legal range 1..255.
- `YELLOW_TIME`, default 5: cycles a road holds yellow; legal range 1..255.
- `ALL_RED_TIME`, default 2: clearance cycles with both roads red; legal range 1..255.
- `clk`  input  1: single clock; all state changes on rising edge.
- `rst`  input  1: reset, asynchronous, active-low (low = reset asserted).
- `light_A`  output  3: road A lamps, one-hot; bit2 = red, bit1 = yellow, bit0 = green.
- `light_B`  output  3: road B lamps, same encoding as `light_A`.

## Operation
- Six states, in fixed cyclic order:
  - `S_AG`: A = 001, B = 100; lasts `GREEN_TIME` cycles.
  - `S_AY`: A = 010, B = 100; lasts `YELLOW_TIME` cycles.
  - `S_RR1`: A = 100, B = 100; lasts `ALL_RED_TIME` cycles.
  - `S_BG`: A = 100, B = 001; lasts `GREEN_TIME` cycles.
  - `S_BY`: A = 100, B = 010; lasts `YELLOW_TIME` cycles.
  - `S_RR2`: A = 100, B = 100; lasts `ALL_RED_TIME` cycles; then returns to `S_AG`.
- Phase counter, 8 bits, counts 0..T-1 within a state, where T is that state's duration. On the edge where counter == T-1, the FSM advances and the counter clears to 0. Otherwise the counter increments.
- Outputs are decoded from the state register only (Moore), with no combinational path from inputs.
- Safety invariants, holding in every cycle including during reset:
  - each light is exactly one-hot;
  - at most one road is non-red;
  - green is never directly followed by red on the same road (yellow always intervenes).
- Unused state encodings recover to `S_AG` with counter 0 on the next edge.
- Parameter value 0 is illegal. The implementation flags it with an elaboration-time check.

## Timing
- Reset asserted (`rst` = 0): state `S_AG`, counter 0, `light_A` = 001, `light_B` = 100, asynchronously, without waiting for a clock edge.
- Reset asserted mid-phase aborts the phase immediately. The sequence restarts from `S_AG`, count 0, after release.
- After release, edge k is the k-th rising edge with `rst` high. With defaults:
  - A green through edge 29; changes at edge 30 to A yellow.
  - Edge 35: all red.
  - Edge 37: B green.
  - Edge 67: B yellow.
  - Edge 72: all red.
  - Edge 74: A green again.
- Full period = 2·(GREEN_TIME + YELLOW_TIME + ALL_RED_TIME) cycles; 74 with defaults.
- Latency from counter terminal to output change: zero extra cycles. Outputs change on the same edge as the state.
- Duration 1 means the state lasts exactly one cycle.

## Structure
- Package `traffic_light_pkg` holds:
  - the state enum (`S_AG`…`S_RR2`);
  - lamp constants `RED` = 3'b100, `YEL` = 3'b010, `GRN` = 3'b001;
  - counter width (8).
- Optional sub-module `phase_timer`: loadable counter with a terminal-count output, taking the active duration as a port.
- Top level = state register, next-state logic, output decode.

## Test plan
- Assert `rst` low mid-count (e.g., during B green at edge 50) -> outputs become A = 001, B = 100 before the next clock edge; after release, A yellow appears at edge 30 counted from the release.
- Reset, release, run 200 cycles with defaults -> transitions at edges 30, 35, 37, 67, 72, 74, 104, 109, … exactly.
- Invariant monitor over 1000 cycles -> both lights always one-hot, never both non-red, and every green→red path on a road passes through yellow.
- Override `GREEN_TIME` = 1, `YELLOW_TIME` = 1, `ALL_RED_TIME` = 1 -> state changes every edge; period 6.
- Override `GREEN_TIME` = 255 -> A green holds for 255 cycles with no counter wrap; transitions at edge 255.
- Force an illegal state encoding -> `S_AG` is restored, with A = 001 and B = 100, after one edge.
